// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation scheduler: state encoding, default
// parameter values and the water-level consistency check.
package irrigation_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SPRINKLE = 3'd1,
    DRIP     = 3'd2,
    REST     = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam int DEF_RUN_TICKS    = 8;
  localparam int DEF_REST_TICKS   = 4;
  localparam int DEF_FAULT_CYCLES = 3;
  localparam int DEF_CNT_W        = 8;

  // Water above a level implies water at every level below it.
  function automatic logic level_inconsistent(input logic low, input logic mid, input logic high);
    return (high & ~mid) | (mid & ~low);
  endfunction

endpackage

// File: rtl/water_fault_filter.sv
// Water-level sensor fault filter: flags a fault after FAULT_CYCLES consecutive inconsistent cycles.
// Latency: fault asserts combinationally in the cycle whose edge completes the run.
// Backpressure: none; free-running on every clock.
module water_fault_filter
  import irrigation_pkg::*;
#(
  parameter int FAULT_CYCLES = DEF_FAULT_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic low_water_level,
  input  logic mid_water_level,
  input  logic high_water_level,
  output logic fault
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAULT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             inc;

  assign inc = level_inconsistent(low_water_level, mid_water_level, high_water_level);

  // Look-ahead: fault is the value the saturating count will reach at this
  // edge, so the FSM enters FAULT on the very edge that completes the run.
  assign fault = inc && (cnt >= (LIMIT - CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (!inc) begin
      cnt <= '0;
    end else if (cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/irrigation_scheduler.sv
// Greenhouse irrigation controller: fill hysteresis, sensor-fault alarm, time-sliced sprinkler/dripper bursts.
// Latency: actuators follow sampled conditions by 1 cycle; timers advance only on tick.
// Backpressure: none; FAULT_LATCH_EN makes the fault state sticky until rst.
module irrigation_scheduler
  import irrigation_pkg::*;
#(
  parameter int RUN_TICKS    = DEF_RUN_TICKS,
  parameter int REST_TICKS   = DEF_REST_TICKS,
  parameter int FAULT_CYCLES = DEF_FAULT_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       low_water_level,
  input  logic       mid_water_level,
  input  logic       high_water_level,
  input  logic       earth_humidity,
  input  logic       air_humidity,
  input  logic       low_temperature,
  output logic       water_supply_valvule,
  output logic       alarm,
  output logic       splinker_bomb,
  output logic       dripper_valvule,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] RUN_LOAD  = CNT_W'(RUN_TICKS);
  localparam logic [CNT_W-1:0] REST_LOAD = CNT_W'(REST_TICKS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic             fill_on;
  logic             fault;
  logic             last_tick;

  water_fault_filter #(
    .FAULT_CYCLES (FAULT_CYCLES),
    .CNT_W        (CNT_W)
  ) u_fault (
    .clk              (clk),
    .rst              (rst),
    .low_water_level  (low_water_level),
    .mid_water_level  (mid_water_level),
    .high_water_level (high_water_level),
    .fault            (fault)
  );

  assign last_tick = tick && (cnt == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      fill_on <= 1'b0;
    end else begin
      if (high_water_level) begin
        fill_on <= 1'b0;
      end else if (!mid_water_level) begin
        fill_on <= 1'b1;
      end

      if (fault) begin
        state_q <= FAULT;
      end else begin
        case (state_q)
          IDLE: begin
            if (!earth_humidity && low_water_level) begin
              cnt     <= RUN_LOAD;
              state_q <= (!air_humidity && !low_temperature && mid_water_level) ? SPRINKLE : DRIP;
            end
          end
          SPRINKLE, DRIP: begin
            // A tick on the stopping edge belongs to the burst; the rest
            // period starts from a full count.
            if (last_tick || earth_humidity || !low_water_level) begin
              state_q <= REST;
              cnt     <= REST_LOAD;
            end else if (tick) begin
              cnt <= cnt - ONE;
            end
          end
          REST: begin
            if (tick) begin
              cnt <= cnt - ONE;
              if (cnt == ONE) begin
                state_q <= IDLE;
              end
            end
          end
          FAULT: begin
`ifdef FAULT_LATCH_EN
            state_q <= FAULT;
`else
            state_q <= REST;
            cnt     <= REST_LOAD;
`endif
          end
          default: begin
            state_q <= IDLE;
            cnt     <= '0;
          end
        endcase
      end
    end
  end

  assign state                = state_q;
  assign splinker_bomb        = (state_q == SPRINKLE);
  assign dripper_valvule      = (state_q == DRIP);
  assign alarm                = (state_q == FAULT);
  assign water_supply_valvule = fill_on & ~alarm;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed bench for irrigation_scheduler: stimulus queues expected output
// vectors tagged with a cycle number, a negedge monitor pops and compares them.
module tb_irrigation_scheduler;

  logic       clk = 1'b0;
  logic       rst, tick;
  logic       low, mid, high, earth, air, temp;
  logic       wsv, alarm, spk, drip;
  logic [2:0] state;

  irrigation_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .tick                 (tick),
    .low_water_level      (low),
    .mid_water_level      (mid),
    .high_water_level     (high),
    .earth_humidity       (earth),
    .air_humidity         (air),
    .low_temperature      (temp),
    .water_supply_valvule (wsv),
    .alarm                (alarm),
    .splinker_bomb        (spk),
    .dripper_valvule      (drip),
    .state                (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [6:0] act;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] mk(input logic [2:0] st, input logic w, input logic a,
                                    input logic s, input logic d);
    return {st, w, a, s, d};
  endfunction

  task automatic expect_now(input string nm, input logic [6:0] v);
    exp_t x;
    x.cyc = cyc;
    x.v   = v;
    x.nm  = nm;
    exp_q.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Three quiet cycles then a one-cycle tick; returns just after the tick edge.
  task automatic tick_n(input int k);
    repeat (k) begin
      step(3);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
    end
  endtask

  // Monitor: output vector is {state, valve, alarm, sprinkler, dripper}.
  always @(negedge clk) begin
    n_cmp++;
    if (spk && drip) begin
      n_fail++;
      $display("FAIL exclusive: sprinkler=%b dripper=%b, required not both 1", spk, drip);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      act = {state, wsv, alarm, spk, drip};
      n_cmp++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, required %b (state,valve,alarm,spk,drip)", e.nm, act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tick = 1'b0;
    low = 1'b1; mid = 1'b1; high = 1'b1;
    earth = 1'b1; air = 1'b0; temp = 1'b0;
    step(2);
    expect_now("reset", mk(3'd0, 0, 0, 0, 0));

    // Sprinkler burst: 8 ticks on, 4 ticks rest, then re-burst.
    rst = 1'b0; earth = 1'b0;
    step(1);
    expect_now("spk_start", mk(3'd1, 0, 0, 1, 0));
    tick_n(7);
    expect_now("spk_tick7", mk(3'd1, 0, 0, 1, 0));
    tick_n(1);
    expect_now("spk_end", mk(3'd3, 0, 0, 0, 0));
    tick_n(3);
    expect_now("rest_hold", mk(3'd3, 0, 0, 0, 0));
    tick_n(1);
    expect_now("rest_done", mk(3'd0, 0, 0, 0, 0));
    step(1);
    expect_now("reburst", mk(3'd1, 0, 0, 1, 0));

    // Early stop: soil turns wet on the 3rd tick; rest counter loads fresh.
    tick_n(2);
    step(3);
    earth = 1'b1; tick = 1'b1;
    step(1);
    tick = 1'b0;
    expect_now("early_stop", mk(3'd3, 0, 0, 0, 0));
    tick_n(3);
    expect_now("early_rest_hold", mk(3'd3, 0, 0, 0, 0));
    tick_n(1);
    expect_now("early_idle", mk(3'd0, 0, 0, 0, 0));

    // Dripper: cold, low+mid present.
    high = 1'b0; temp = 1'b1; earth = 1'b0;
    step(1);
    expect_now("drip_start", mk(3'd2, 0, 0, 0, 1));
    tick_n(7);
    expect_now("drip_tick7", mk(3'd2, 0, 0, 0, 1));
    tick_n(1);
    expect_now("drip_end", mk(3'd3, 0, 0, 0, 0));
    tick_n(4);
    expect_now("drip_rest_done", mk(3'd0, 0, 0, 0, 0));
    step(1);
    expect_now("drip_again", mk(3'd2, 0, 0, 0, 1));

    // Reset mid-burst with a coincident tick; no rest afterwards.
    tick_n(2);
    step(3);
    rst = 1'b1; tick = 1'b1;
    step(1);
    rst = 1'b0; tick = 1'b0;
    expect_now("rst_mid_drip", mk(3'd0, 0, 0, 0, 0));
    step(1);
    expect_now("rst_no_rest", mk(3'd2, 0, 0, 0, 1));
    earth = 1'b1;
    step(1);
    expect_now("wet_stop", mk(3'd3, 0, 0, 0, 0));
    tick_n(4);
    expect_now("wet_idle", mk(3'd0, 0, 0, 0, 0));

    // Fill hysteresis.
    high = 1'b1;
    step(1);
    mid = 1'b0; high = 1'b0;
    expect_now("fill_pre", mk(3'd0, 0, 0, 0, 0));
    step(1);
    expect_now("fill_open", mk(3'd0, 1, 0, 0, 0));
    mid = 1'b1;
    step(2);
    expect_now("fill_hold", mk(3'd0, 1, 0, 0, 0));
    high = 1'b1;
    step(1);
    expect_now("fill_close", mk(3'd0, 0, 0, 0, 0));

    // Sensor fault filter: 2-cycle glitch ignored, 3 cycles raise alarm.
    mid = 1'b0; high = 1'b0;
    step(1);
    mid = 1'b1; low = 1'b0;
    step(2);
    expect_now("glitch2", mk(3'd0, 1, 0, 0, 0));
    low = 1'b1;
    step(1);
    expect_now("glitch_clear", mk(3'd0, 1, 0, 0, 0));
    low = 1'b0;
    step(2);
    expect_now("fault_pre", mk(3'd0, 1, 0, 0, 0));
    step(1);
    expect_now("fault_on", mk(3'd4, 0, 1, 0, 0));
    step(2);
    expect_now("fault_hold", mk(3'd4, 0, 1, 0, 0));
    low = 1'b1;
    step(1);
`ifdef FAULT_LATCH_EN
    expect_now("fault_sticky", mk(3'd4, 0, 1, 0, 0));
    tick_n(4);
    expect_now("fault_sticky_late", mk(3'd4, 0, 1, 0, 0));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    expect_now("fault_rst", mk(3'd0, 0, 0, 0, 0));
`else
    expect_now("fault_exit", mk(3'd3, 1, 0, 0, 0));
    tick_n(3);
    expect_now("fault_rest_hold", mk(3'd3, 1, 0, 0, 0));
    tick_n(1);
    expect_now("fault_rest_done", mk(3'd0, 1, 0, 0, 0));
`endif

    step(3);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
